line_fill_ctrl: RTL and testbench

LINE_FILL_CTRL -- requirements
Module: line_fill_ctrl

---
 rtl/line_fill_ctrl.sv | 155 +++++++++++++++
 tb/tb_line_fill_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_ctrl.sv
// rtl/line_fill_ctrl.sv - cache line writeback/fill controller; option macro LINE_FILL_CRITICAL_WORD_FIRST_EN
module line_fill_ctrl #(
    parameter int LINE_WORDS     = 4,
    parameter int LINE_ADDR_BITS = 10
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic                                          req_evict,
    input  logic [LINE_ADDR_BITS-1:0]                     req_fill_addr,
    input  logic [$clog2(LINE_WORDS)-1:0]                 req_word,
    input  logic [LINE_ADDR_BITS-1:0]                     req_evict_addr,
    input  logic [32*LINE_WORDS-1:0]                      req_evict_data,
    output logic                                          fill_valid,
    output logic [32*LINE_WORDS-1:0]                      fill_data,
    output logic                                          crit_valid,
    output logic [31:0]                                   crit_data,
    output logic [LINE_ADDR_BITS+$clog2(LINE_WORDS)-1:0]  mem_addr,
    output logic                                          mem_we,
    output logic                                          mem_re,
    output logic [31:0]                                   mem_wdata,
    input  logic [31:0]                                   mem_rdata,
    output logic                                          busy
);

    localparam int WB = $clog2(LINE_WORDS);
    // Counter is one bit wider than a word index: READ needs LINE_WORDS+1 cycles.
    localparam logic [WB:0] CNT_WLAST = (WB+1)'(LINE_WORDS - 1);
    localparam logic [WB:0] CNT_RLAST = (WB+1)'(LINE_WORDS);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_READ      = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [WB:0]                 cnt_q, cnt_d;
    logic [LINE_ADDR_BITS-1:0]   fill_addr_q;
    logic [LINE_ADDR_BITS-1:0]   evict_addr_q;
    logic [32*LINE_WORDS-1:0]    evict_data_q;
    logic [WB-1:0]               word_q;
    logic                        rd_pend_q;
    logic [WB-1:0]               rd_slot_q;
    logic [32*LINE_WORDS-1:0]    fill_data_q;
    logic [31:0]                 crit_data_q;
    logic                        crit_valid_q;
    logic [WB-1:0]               rd_base;
    logic [WB-1:0]               issue_idx;
    logic                        accept;

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    // Reads start at the word the CPU is stalled on and wrap around the line.
    assign rd_base = word_q;
`else
    assign rd_base = '0;
`endif

    // Index arithmetic is WB bits wide so it wraps modulo LINE_WORDS for free.
    assign issue_idx  = rd_base + cnt_q[WB-1:0];
    assign req_ready  = (state_q == S_IDLE) && rst_n;
    assign accept     = req_valid && req_ready;
    assign busy       = (state_q != S_IDLE);
    assign fill_valid = (state_q == S_DONE);
    assign fill_data  = fill_data_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;

    // Next-state and memory strobes; memory outputs are zero unless in use.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = req_evict ? S_WRITEBACK : S_READ;
                end
            end
            S_WRITEBACK: begin
                mem_we    = 1'b1;
                mem_addr  = {evict_addr_q, cnt_q[WB-1:0]};
                mem_wdata = evict_data_q[{cnt_q[WB-1:0], 5'd0} +: 32];
                if (cnt_q == CNT_WLAST) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ: begin
                if (cnt_q != CNT_RLAST) begin
                    mem_re   = 1'b1;
                    mem_addr = {fill_addr_q, issue_idx};
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    // Final READ cycle only collects the last returning word.
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, request latch and read-data capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            fill_addr_q  <= '0;
            evict_addr_q <= '0;
            evict_data_q <= '0;
            word_q       <= '0;
            rd_pend_q    <= 1'b0;
            rd_slot_q    <= '0;
            fill_data_q  <= '0;
            crit_data_q  <= '0;
            crit_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                fill_addr_q  <= req_fill_addr;
                evict_addr_q <= req_evict_addr;
                evict_data_q <= req_evict_data;
                word_q       <= req_word;
            end
            // mem_rdata answers the read issued one cycle earlier.
            rd_pend_q    <= mem_re;
            rd_slot_q    <= issue_idx;
            crit_valid_q <= 1'b0;
            if (rd_pend_q) begin
                fill_data_q[{rd_slot_q, 5'd0} +: 32] <= mem_rdata;
                if (rd_slot_q == word_q) begin
                    crit_data_q  <= mem_rdata;
                    crit_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// tb/tb_line_fill_ctrl.sv - randomized self-checking bench for line_fill_ctrl against a transaction model
module tb_line_fill_ctrl;

    localparam int LW = 4;
    localparam int AB = 10;
    localparam int WB = 2;
    localparam int AW = AB + WB;
    localparam int DW = 32 * LW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_evict = 1'b0;
    logic [AB-1:0] req_fill_addr = '0;
    logic [WB-1:0] req_word = '0;
    logic [AB-1:0] req_evict_addr = '0;
    logic [DW-1:0] req_evict_data = '0;
    logic          fill_valid;
    logic [DW-1:0] fill_data;
    logic          crit_valid;
    logic [31:0]   crit_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic          busy;

    always #5 clk = ~clk;

    line_fill_ctrl #(.LINE_WORDS(LW), .LINE_ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_evict(req_evict),
        .req_fill_addr(req_fill_addr), .req_word(req_word),
        .req_evict_addr(req_evict_addr), .req_evict_data(req_evict_data),
        .fill_valid(fill_valid), .fill_data(fill_data),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Backing RAM seen by the DUT, and an independent copy the model keeps.
    logic [31:0] ram     [0:(1<<AW)-1];
    logic [31:0] ref_ram [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, want);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out", nm);
    endtask

    typedef struct {
        logic          ready, busy, we, re, fv, cv;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   cdata;
        logic [DW-1:0] line;
    } exp_t;

    exp_t          sched_q[$];
    exp_t          cur;
    bit            idle;
    int            cyc = 0, acc_cnt = 0, acc_cyc = 0, fv_cyc = 0, cv_cyc = 0;
    logic [DW-1:0] last_line = '0;
    logic [31:0]   last_crit = '0;
    logic [DW-1:0] fv_data = '0;
    logic [AW-1:0] rd_log[$];
    logic [AW+31:0] wr_log[$];

    function automatic exp_t blank(input logic rdy, input logic bsy);
        exp_t r;
        r.ready = rdy; r.busy = bsy; r.we = 0; r.re = 0; r.fv = 0; r.cv = 0;
        r.addr = '0; r.wdata = '0; r.cdata = '0; r.line = '0;
        return r;
    endfunction

    // Expand one accepted request into its expected cycle-by-cycle outputs.
    task automatic build(input logic ev, input logic [AB-1:0] ea, input logic [DW-1:0] ed,
                         input logic [AB-1:0] fa, input logic [WB-1:0] w);
        exp_t          r;
        logic [DW-1:0] line;
        logic [WB-1:0] kk;
        int            base, p, o;
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
        base = int'(w);
`else
        base = 0;
`endif
        for (int k = 0; k < LW; k++) begin
            kk = k[WB-1:0];
            line[32*k +: 32] = (ev && ea == fa) ? ed[32*k +: 32] : ref_ram[{fa, kk}];
        end
        if (ev) begin
            for (int k = 0; k < LW; k++) begin
                kk = k[WB-1:0];
                r = blank(0, 1);
                r.we = 1; r.addr = {ea, kk}; r.wdata = ed[32*k +: 32];
                sched_q.push_back(r);
            end
        end
        p = (int'(w) - base + LW) % LW;
        for (int j = 0; j <= LW + 1; j++) begin
            r = blank(0, 1);
            if (j < LW) begin
                o = (base + j) % LW;
                r.re = 1; r.addr = {fa, o[WB-1:0]};
            end
            if (j == LW + 1) begin
                r.fv = 1; r.line = line;
            end
            if (j == p + 2) begin
                r.cv = 1; r.cdata = line[32*w +: 32];
            end
            sched_q.push_back(r);
        end
    endtask

    // Compare DUT outputs to the model mid-cycle; also detect accepts.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sched_q.delete();
            last_line = '0;
            last_crit = '0;
            chk("reset_ctl", {req_ready, busy, mem_we, mem_re, fill_valid, crit_valid}, '0);
            chk("reset_mem", {mem_addr, mem_wdata}, '0);
            chk("reset_fill", fill_data, '0);
            chk("reset_crit", crit_data, '0);
        end else begin
            idle = (sched_q.size() == 0);
            if (idle) cur = blank(1, 0);
            else cur = sched_q.pop_front();
            chk("ctl", {req_ready, busy, mem_we, mem_re, fill_valid, crit_valid},
                {cur.ready, cur.busy, cur.we, cur.re, cur.fv, cur.cv});
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_wdata", mem_wdata, cur.wdata);
            if (cur.fv) begin
                chk("fill_data", fill_data, cur.line);
                last_line = cur.line;
                fv_cyc = cyc;
                fv_data = fill_data;
            end
            if (cur.cv) begin
                chk("crit_data", crit_data, cur.cdata);
                last_crit = cur.cdata;
            end
            if (idle) begin
                chk("fill_hold", fill_data, last_line);
                chk("crit_hold", crit_data, last_crit);
            end
            if (cur.we) ref_ram[cur.addr] = cur.wdata;
            if (mem_re) rd_log.push_back(mem_addr);
            if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
            if (crit_valid) cv_cyc = cyc;
            if (idle && req_valid) begin
                acc_cnt++;
                acc_cyc = cyc;
                build(req_evict, req_evict_addr, req_evict_data, req_fill_addr, req_word);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_fields();
        req_evict      = 1'($urandom_range(0, 1));
        req_evict_addr = AB'($urandom_range(0, 7));
        req_fill_addr  = AB'($urandom_range(0, 7));
        req_word       = WB'($urandom_range(0, LW - 1));
        for (int k = 0; k < LW; k++) req_evict_data[32*k +: 32] = $urandom;
    endtask

    task automatic run_req(input logic ev, input logic [AB-1:0] ea, input logic [DW-1:0] ed,
                           input logic [AB-1:0] fa, input logic [WB-1:0] w,
                           input bit wait_done, input bit scramble);
        int n0, t;
        n0 = acc_cnt;
        req_evict = ev; req_evict_addr = ea; req_evict_data = ed;
        req_fill_addr = fa; req_word = w; req_valid = 1'b1;
        t = 0;
        while (acc_cnt == n0 && t < 50) begin step(); t++; end
        if (acc_cnt == n0) timeout_fail("accept");
        req_valid = 1'b0;
        if (wait_done) begin
            t = 0;
            while (sched_q.size() != 0 && t < 100) begin
                if (scramble) begin
                    rand_fields();
                    req_valid = 1'($urandom_range(0, 1));
                end
                step();
                t++;
            end
            req_valid = 1'b0;
            if (sched_q.size() != 0) timeout_fail("done");
        end
    endtask

    logic [AW-1:0] exp_rd[LW];
    logic [DW-1:0] rd_ed;
    int            n0, t;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = $urandom;
            ref_ram[i] = ram[i];
        end
        for (int k = 0; k < LW; k++) begin
            ram[12'h014 + k] = 32'hA000_00A0 + k;
            ref_ram[12'h014 + k] = 32'hA000_00A0 + k;
        end
        repeat (3) step();
        chk("ready_in_reset", req_ready, 1'b0);
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", req_ready, 1'b1);

        // Plain fill of line 0x005, CPU waiting on word 3; inputs scrambled while busy.
        rd_log.delete(); wr_log.delete();
        run_req(1'b0, '0, '0, 10'h005, 2'd3, 1'b1, 1'b1);
        chk("fill_latency", fv_cyc - acc_cyc, 6);
        chk("fill_literal", fv_data, 128'hA00000A3_A00000A2_A00000A1_A00000A0);
        chk("no_writes", wr_log.size(), 0);
        chk("read_count", rd_log.size(), LW);
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
        exp_rd = '{12'h017, 12'h014, 12'h015, 12'h016};
        chk("crit_latency", cv_cyc - acc_cyc, 3);
`else
        exp_rd = '{12'h014, 12'h015, 12'h016, 12'h017};
        chk("crit_latency", cv_cyc - acc_cyc, 6);
`endif
        for (int k = 0; k < LW && k < rd_log.size(); k++) chk("read_order", rd_log[k], exp_rd[k]);
        chk("crit_literal", crit_data, 32'hA00000A3);

        // Eviction of line 0x002 then fill of line 0x007.
        rd_log.delete(); wr_log.delete();
        run_req(1'b1, 10'h002, 128'hD00000D3_D00000D2_D00000D1_D00000D0, 10'h007, 2'd0, 1'b1, 1'b0);
        chk("evict_latency", fv_cyc - acc_cyc, 10);
        chk("write_count", wr_log.size(), LW);
        for (int k = 0; k < LW && k < wr_log.size(); k++)
            chk("write_seq", wr_log[k], {AW'(12'h008 + k), 32'hD00000D0 + k});
        chk("evict_read_count", rd_log.size(), LW);
        for (int k = 0; k < LW && k < rd_log.size(); k++)
            chk("evict_read_seq", rd_log[k], AW'(12'h01C + k));

        // req_valid held across two requests.
        n0 = acc_cnt;
        req_evict = 1'b0; req_fill_addr = 10'h001; req_word = 2'd1; req_valid = 1'b1;
        t = 0;
        while (acc_cnt < n0 + 2 && t < 60) begin step(); t++; end
        if (acc_cnt < n0 + 2) timeout_fail("b2b_accept");
        else chk("b2b_gap", acc_cyc - fv_cyc, 1);
        req_valid = 1'b0;
        t = 0;
        while (sched_q.size() != 0 && t < 100) begin step(); t++; end
        if (sched_q.size() != 0) timeout_fail("b2b_done");

        // Reset pulsed during the second writeback cycle.
        wr_log.delete();
        run_req(1'b1, 10'h003, 128'hE00000E3_E00000E2_E00000E1_E00000E0, 10'h004, 2'd2, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("async_ctl", {req_ready, busy, mem_we, mem_re, fill_valid, crit_valid}, '0);
        chk("async_mem", {mem_addr, mem_wdata}, '0);
        chk("async_fill", fill_data, '0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_idle", {busy, req_ready}, 2'b01);
        chk("reset_write_count", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("reset_write_word", wr_log[0], {12'h00C, 32'hE00000E0});

        // Randomized traffic with idle gaps and scrambled inputs while busy.
        for (int n = 0; n < 40; n++) begin
            t = $urandom_range(0, 3);
            for (int g = 0; g < t; g++) begin
                rand_fields();
                req_valid = 1'b0;
                step();
            end
            rand_fields();
            rd_ed = req_evict_data;
            run_req(req_evict, req_evict_addr, rd_ed, req_fill_addr, req_word, 1'b1, 1'b1);
        end
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
